// File: rtl/spi_byte_slave_pkg.sv
// Shared constants and state type for the SPI byte slave.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;
   localparam int unsigned SPI_CNT_W  = 3;

   typedef enum logic {
      SPI_IDLE,
      SPI_ACTIVE
   } spi_state_e;

endpackage

// File: rtl/spi_byte_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detection
// taken from one extra flop behind the synchronised level.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Shift the pin through the synchroniser chain and keep the previous level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI/DC into clk_i,
// assembles received bytes and shifts a return byte out on MISO.
module spi_byte_slave
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        MISO_IDLE   = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_sclk_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_mosi_i,
   input  logic                  spi_dc_i,
   output logic                  spi_miso_o,
   output logic                  spi_byte_vld_o,
   output logic [SPI_BYTE_W-1:0] spi_byte_data_o,
   output logic                  spi_byte_dc_o,
   input  logic [SPI_BYTE_W-1:0] spi_tx_data_i,
   output logic                  spi_tx_load_o
);

   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_mosi, w_dc;
   logic w_tx_load;

   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_dc_sync;

   spi_state_e r_state, w_state_nxt;

   logic [SPI_CNT_W-1:0]  r_cnt;
   logic [SPI_BYTE_W-1:0] r_rx_shift;
   logic [SPI_BYTE_W-1:0] r_tx_shift;
   logic [SPI_BYTE_W-1:0] r_byte_data;
   logic                  r_byte_dc;
   logic                  r_byte_done;
   logic                  r_byte_vld;
   logic                  r_byte_end;
   logic                  r_miso;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_sclk_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_async (spi_sclk_i),
      .o_level (w_sclk_level),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_cs_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_async (spi_cs_n_i),
      .o_level (w_cs_level),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   // Level-only synchronisers for MOSI and DC, same depth as SCLK so the
   // data bit lines up with the detected SCLK edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mosi_sync <= '0;
         r_dc_sync   <= '0;
      end else begin
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc_i};
      end
   end

   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_dc   = r_dc_sync[SYNC_STAGES-1];

   // Frame state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= SPI_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and TX-load strobe; cs_rise takes priority over SCLK edges.
   always_comb begin
      w_state_nxt = r_state;
      w_tx_load   = 1'b0;
      unique case (r_state)
         SPI_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = SPI_ACTIVE;
               w_tx_load   = ~rst_i;
            end
         end
         SPI_ACTIVE: begin
            if (w_cs_rise) begin
               w_state_nxt = SPI_IDLE;
            end else if (w_sclk_fall && r_byte_end) begin
               w_tx_load = ~rst_i;
            end
         end
         default: w_state_nxt = SPI_IDLE;
      endcase
   end

   // RX/TX shifting, byte capture and MISO drive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt       <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_byte_data <= '0;
         r_byte_dc   <= 1'b0;
         r_byte_done <= 1'b0;
         r_byte_vld  <= 1'b0;
         r_byte_end  <= 1'b0;
         r_miso      <= MISO_IDLE;
      end else begin
         r_byte_done <= 1'b0;
         r_byte_vld  <= r_byte_done;
         if (r_state == SPI_IDLE) begin
            if (w_cs_fall) begin
               r_cnt      <= '0;
               r_byte_end <= 1'b0;
               r_tx_shift <= spi_tx_data_i;
               r_miso     <= spi_tx_data_i[SPI_BYTE_W-1];
            end
         end else if (w_cs_rise) begin
            r_cnt      <= '0;
            r_byte_end <= 1'b0;
            r_miso     <= MISO_IDLE;
         end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
               r_byte_data <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
               r_byte_dc   <= w_dc;
               r_byte_done <= 1'b1;
               r_byte_end  <= 1'b1;
            end
         end else if (w_sclk_fall) begin
            if (r_byte_end) begin
               r_byte_end <= 1'b0;
               r_tx_shift <= spi_tx_data_i;
               r_miso     <= spi_tx_data_i[SPI_BYTE_W-1];
            end else begin
               r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
               r_miso     <= r_tx_shift[SPI_BYTE_W-2];
            end
         end
      end
   end

   assign spi_miso_o      = r_miso;
   assign spi_byte_vld_o  = r_byte_vld;
   assign spi_byte_data_o = r_byte_data;
   assign spi_byte_dc_o   = r_byte_dc;
   assign spi_tx_load_o   = w_tx_load;

   logic w_unused;
   assign w_unused = w_sclk_level ^ w_cs_level;

endmodule

// File: doc/spi_byte_slave.md
Name: spi_byte_slave

Overview:
- SPI mode-0 slave front end that turns the external SPI pins (SCLK, CS_N, MOSI, DC) into a byte stream: one-cycle byte-valid pulse, 8-bit data and DC flag.
- Feeds the RAM read/write command decoder, which consumes byte_vld/byte_data/dc.
- Also shifts a return byte out on MISO so the host can read back RAM contents.
- Oversampled design: all pins are synchronised into clk_i; no logic runs on SCLK.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for SCLK/CS_N/MOSI/DC (legal 2..4).
- MISO_IDLE, 1'b0, MISO level while CS_N is high or no byte is loaded.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- spi_sclk_i  in  1  SPI clock, asynchronous, CPOL=0.
- spi_cs_n_i  in  1  SPI chip select, active low, asynchronous.
- spi_mosi_i  in  1  SPI data in, MSB first.
- spi_dc_i  in  1  data/command pin, asynchronous (1 = data, 0 = command).
- spi_miso_o  out  1  SPI data out, MSB first.
- spi_byte_vld_o  out  1  one-cycle pulse: byte received.
- spi_byte_data_o  out  8  received byte, held until next pulse.
- spi_byte_dc_o  out  1  DC level captured with the byte, held until next pulse.
- spi_tx_data_i  in  8  byte to return on MISO.
- spi_tx_load_o  out  1  one-cycle pulse: spi_tx_data_i sampled into the TX shifter this cycle.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): all synchroniser flops set to idle (sclk=0, cs_n=1, mosi=0, dc=0).
  - Bit counter=0; RX and TX shifters=0.
  - spi_byte_vld_o=0, spi_byte_data_o=8'h00, spi_byte_dc_o=0, spi_tx_load_o=0, spi_miso_o=MISO_IDLE.
- Synchronisation: each pin passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - sclk_rise = sync & ~prev; sclk_fall = ~sync & prev; cs_fall and cs_rise are defined the same way.
- States (2): IDLE (cs_n_sync=1) and ACTIVE (cs_n_sync=0).
  - IDLE -> ACTIVE on cs_fall; ACTIVE -> IDLE on cs_rise.
  - SCLK edges seen in IDLE are ignored.
- On entering ACTIVE (cs_fall cycle):
  - bit counter=0.
  - TX shifter <= spi_tx_data_i; spi_tx_load_o pulses in the same cycle.
  - spi_miso_o <= spi_tx_data_i[7].
- RX, in ACTIVE on sclk_rise: rx_shift <= {rx_shift[6:0], mosi_sync}; counter++.
  - On the 8th rise (counter 7->0): spi_byte_data_o <= {rx_shift[6:0], mosi_sync}, spi_byte_dc_o <= dc_sync.
  - spi_byte_vld_o=1 in the cycle after that edge-detect cycle, for exactly 1 cycle.
- Latency: SCLK 8th rising pin edge to spi_byte_vld_o high is SYNC_STAGES+2 clk_i cycles.
- TX, in ACTIVE on sclk_fall: tx_shift <= {tx_shift[6:0],1'b0}; spi_miso_o <= tx_shift[6].
  - If that fall ends a byte (counter==0 after 8 rises), instead:
    - tx_shift <= spi_tx_data_i; spi_miso_o <= spi_tx_data_i[7].
    - spi_tx_load_o pulses 1 cycle.
  - Consequence: the consumer must present the next TX byte by the falling edge after byte_vld.
- CS_N rising mid-byte (counter != 0):
  - Partial byte discarded; no vld pulse; counter=0.
  - spi_miso_o=MISO_IDLE; held outputs unchanged.
- Simultaneous cs_rise and sclk_rise in one cycle: cs_rise wins; the edge is ignored.
- Reset mid-transfer: as reset; the next byte counts only after a fresh cs_fall.
- SCLK constraint: SCLK high and low phases each >= SYNC_STAGES+1 clk_i periods. Faster SCLK is unsupported (bytes may be lost, no detection).
- DC is sampled once per byte at the 8th rise only; DC changes mid-byte are irrelevant.

Decomposition:
- Package spi_pkg: SPI_BYTE_W=8, bit counter width localparam (3), typedef enum logic {SPI_IDLE, SPI_ACTIVE}.
- Sub-module sync_edge (SYNC_STAGES, RESET_VAL):
  - Outputs the synchronised level, rise and fall.
  - Instanced for sclk and cs_n; mosi and dc use level only.

Test Plan:
- Reset: hold rst_i 3 cycles with CS_N=1 -> all outputs at reset values; MISO=MISO_IDLE; no vld.
- Command byte: CS_N low, DC=0, shift 8'h2c MSB-first (SCLK half-period 4 clk) -> exactly one vld, data=8'h2c, dc=0, SYNC_STAGES+2 cycles after 8th SCLK rise.
- Data burst: DC=1, 32 bytes 0x00..0x1f in one CS frame -> 32 vld pulses in order, each dc=1, no gaps or duplicates.
- Readback: spi_tx_data_i=8'hA5 at cs_fall, then 8'h3C -> MISO sampled on rising SCLK reads A5 then 3C; spi_tx_load_o pulses at cs_fall and after byte 1.
- Abort: CS_N high after 5 bits of 8'hff, then new frame sending 8'h2b -> no vld for the partial byte; next vld data=8'h2b.
- Reset mid-byte: assert rst_i after 4 bits, release, new frame with 8'h2a -> no spurious vld; single vld data=8'h2a.
